// File: rtl/garegga_cen_gen.sv
// garegga_cen_gen: fractional-N clock-enable generator for the garegga core.
// Six phase accumulators run on the 96 MHz system clock. Each one produces a
// main strobe when its phase wraps and a "B" twin when its phase crosses the
// half-period point. The 6.75 MHz pixel enables are derived from the 13.5 MHz
// channel by a toggle, so the pixel and pixel-x2 enables stay phase-locked.
// The sound enables are muxed per game from the registered strobes.
module garegga_cen_gen #(
  parameter int ACC_W   = 10,
  parameter int PX_NUM  = 9,
  parameter int PX_DEN  = 64,
  parameter int F4_NUM  = 1,
  parameter int F4_DEN  = 24,
  parameter int F2_NUM  = 1,
  parameter int F2_DEN  = 48,
  parameter int F3_NUM  = 9,
  parameter int F3_DEN  = 256,
  parameter int F16_NUM = 9,
  parameter int F16_DEN = 512,
  parameter int F1_NUM  = 1,
  parameter int F1_DEN  = 96
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       HOLD,
  input  logic [7:0] GAME,
  output logic       CEN1350,
  output logic       CEN1350B,
  output logic       CEN675,
  output logic       CEN675B,
  output logic       CEN4,
  output logic       CEN4B,
  output logic       CEN2,
  output logic       CEN2B,
  output logic       CEN3P375,
  output logic       CEN3P375B,
  output logic       CEN1P6875,
  output logic       CEN1P6875B,
  output logic       CEN1,
  output logic       CEN1B,
  output logic       YM_CEN,
  output logic       YM_CEN2,
  output logic       OKI_CEN,
  output logic       Z80_CEN
);

  // Channel order: 0 PX (13.5 MHz), 1 F4, 2 F2, 3 F3 (3.375), 4 F16 (1.6875), 5 F1.
  localparam int NCH = 6;

  // Phase increment of a channel, widened to the accumulator sum width.
  function automatic logic [ACC_W:0] ch_num(input logic [2:0] idx);
    case (idx)
      3'd0:    ch_num = (ACC_W+1)'(PX_NUM);
      3'd1:    ch_num = (ACC_W+1)'(F4_NUM);
      3'd2:    ch_num = (ACC_W+1)'(F2_NUM);
      3'd3:    ch_num = (ACC_W+1)'(F3_NUM);
      3'd4:    ch_num = (ACC_W+1)'(F16_NUM);
      3'd5:    ch_num = (ACC_W+1)'(F1_NUM);
      default: ch_num = {(ACC_W+1){1'b0}};
    endcase
  endfunction

  // Phase modulus of a channel, widened to the accumulator sum width.
  function automatic logic [ACC_W:0] ch_den(input logic [2:0] idx);
    case (idx)
      3'd0:    ch_den = (ACC_W+1)'(PX_DEN);
      3'd1:    ch_den = (ACC_W+1)'(F4_DEN);
      3'd2:    ch_den = (ACC_W+1)'(F2_DEN);
      3'd3:    ch_den = (ACC_W+1)'(F3_DEN);
      3'd4:    ch_den = (ACC_W+1)'(F16_DEN);
      3'd5:    ch_den = (ACC_W+1)'(F1_DEN);
      default: ch_den = {(ACC_W+1){1'b1}};
    endcase
  endfunction

  logic [ACC_W-1:0] acc_q  [NCH];
  logic [ACC_W-1:0] acc_d  [NCH];
  logic [ACC_W:0]   sum_s  [NCH];
  logic [ACC_W:0]   wrap_s [NCH];
  logic [ACC_W:0]   half_s [NCH];
  logic [NCH-1:0]   cen_q;
  logic [NCH-1:0]   cen_d;
  logic [NCH-1:0]   cenb_q;
  logic [NCH-1:0]   cenb_d;
  logic             px_tog_q;
  logic             cen675_q;
  logic             cen675b_q;
  logic [7:0]       game_q;
  logic             ym_prev_q;
  logic             ym2_prev_q;
  logic             oki_prev_q;
  logic             alt_sel_s;
  logic             ym_raw_s;
  logic             ym2_raw_s;
  logic             oki_raw_s;

  // Next phase and strobe decisions for every accumulator channel.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      sum_s[i]  = {1'b0, acc_q[i]} + ch_num(3'(i));
      wrap_s[i] = sum_s[i] - ch_den(3'(i));
      half_s[i] = ch_den(3'(i)) >> 1;
      if (sum_s[i] >= ch_den(3'(i))) begin
        acc_d[i] = wrap_s[i][ACC_W-1:0];
        cen_d[i] = 1'b1;
      end else begin
        acc_d[i] = sum_s[i][ACC_W-1:0];
        cen_d[i] = 1'b0;
      end
      // B twin fires on the edge where the phase first reaches half-period.
      cenb_d[i] = ({1'b0, acc_q[i]} < half_s[i]) && (sum_s[i] >= half_s[i]) &&
                  (sum_s[i] < ch_den(3'(i)));
    end
  end

  // Accumulator, strobe, pixel-toggle and game-select registers.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      for (int i = 0; i < NCH; i++) begin
        acc_q[i] <= {ACC_W{1'b0}};
      end
      cen_q      <= {NCH{1'b0}};
      cenb_q     <= {NCH{1'b0}};
      px_tog_q   <= 1'b0;
      cen675_q   <= 1'b0;
      cen675b_q  <= 1'b0;
      game_q     <= 8'd0;
      ym_prev_q  <= 1'b0;
      ym2_prev_q <= 1'b0;
      oki_prev_q <= 1'b0;
    end else begin
      game_q     <= GAME;
      ym_prev_q  <= YM_CEN;
      ym2_prev_q <= YM_CEN2;
      oki_prev_q <= OKI_CEN;
      if (HOLD) begin
        // Phase is frozen; only the strobes are silenced.
        cen_q     <= {NCH{1'b0}};
        cenb_q    <= {NCH{1'b0}};
        cen675_q  <= 1'b0;
        cen675b_q <= 1'b0;
      end else begin
        for (int i = 0; i < NCH; i++) begin
          acc_q[i] <= acc_d[i];
        end
        cen_q     <= cen_d;
        cenb_q    <= cenb_d;
        // Pixel enable takes every 2nd pixel-x2 pulse starting with the 2nd;
        // its twin takes the 1st, 3rd, ... pulses.
        px_tog_q  <= px_tog_q ^ cen_d[0];
        cen675_q  <= cen_d[0] & px_tog_q;
        cen675b_q <= cen_d[0] & ~px_tog_q;
      end
    end
  end

  // Per-game sound clock selection from the registered strobes and game copy.
  always_comb begin
    alt_sel_s = (game_q == 8'd1) || (game_q == 8'd2);
    if (alt_sel_s) begin
      ym_raw_s  = cen_q[3];
      ym2_raw_s = cen_q[4];
      oki_raw_s = cen_q[5];
    end else begin
      ym_raw_s  = cen_q[1];
      ym2_raw_s = cen_q[2];
      oki_raw_s = cen_q[2];
    end
    // A single channel never pulses on adjacent cycles, so the previous-cycle
    // mask only bites at a game switch, where it stops a widened pulse.
    YM_CEN  = ym_raw_s & ~ym_prev_q;
    YM_CEN2 = ym2_raw_s & ~ym2_prev_q;
    OKI_CEN = oki_raw_s & ~oki_prev_q;
  end

  assign CEN1350    = cen_q[0];
  assign CEN1350B   = cenb_q[0];
  assign CEN675     = cen675_q;
  assign CEN675B    = cen675b_q;
  assign CEN4       = cen_q[1];
  assign CEN4B      = cenb_q[1];
  assign CEN2       = cen_q[2];
  assign CEN2B      = cenb_q[2];
  assign CEN3P375   = cen_q[3];
  assign CEN3P375B  = cenb_q[3];
  assign CEN1P6875  = cen_q[4];
  assign CEN1P6875B = cenb_q[4];
  assign CEN1       = cen_q[5];
  assign CEN1B      = cenb_q[5];
  assign Z80_CEN    = cen_q[1];

endmodule

// File: tb/tb_garegga_cen_gen.sv
// Scoreboard bench for garegga_cen_gen. The stimulus process drives one cycle
// at a time, derives the expected strobe vector from the enabled-edge count
// with floor arithmetic, and queues it; the monitor pops and compares after
// every clock edge.
module tb_garegga_cen_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hold;
  logic [7:0] game;
  logic CEN1350, CEN1350B, CEN675, CEN675B, CEN4, CEN4B, CEN2, CEN2B;
  logic CEN3P375, CEN3P375B, CEN1P6875, CEN1P6875B, CEN1, CEN1B;
  logic YM_CEN, YM_CEN2, OKI_CEN, Z80_CEN;

  always #5 clk = ~clk;

  garegga_cen_gen dut (
    .CLK(clk), .RESET_N(rst_n), .HOLD(hold), .GAME(game),
    .CEN1350(CEN1350), .CEN1350B(CEN1350B), .CEN675(CEN675), .CEN675B(CEN675B),
    .CEN4(CEN4), .CEN4B(CEN4B), .CEN2(CEN2), .CEN2B(CEN2B),
    .CEN3P375(CEN3P375), .CEN3P375B(CEN3P375B),
    .CEN1P6875(CEN1P6875), .CEN1P6875B(CEN1P6875B),
    .CEN1(CEN1), .CEN1B(CEN1B),
    .YM_CEN(YM_CEN), .YM_CEN2(YM_CEN2), .OKI_CEN(OKI_CEN), .Z80_CEN(Z80_CEN)
  );

  // Vector bit order, 17 down to 0:
  // 1350 1350B 675 675B 4 4B 2 2B 3.375 3.375B 1.6875 1.6875B 1 1B YM YM2 OKI Z80
  typedef struct {
    logic [17:0] exp;
    logic [17:0] msk;
    bit          cnt;
    longint      n;
    bit          rst;
  } ent_t;

  ent_t        q[$];
  int          checks = 0;
  int          failures = 0;
  longint      n = 0;
  logic [7:0]  game_reg = 8'd0;
  int          cnt[18];
  longint      first4 = 0;
  longint      first4b = 0;

  function automatic bit strobe(input longint k, input longint num, input longint den);
    return ((k * num) / den) != (((k - 1) * num) / den);
  endfunction

  function automatic bit strobe_b(input longint k, input longint num, input longint den);
    longint off;
    off = den - den / 2;
    return ((k * num + off) / den) != (((k - 1) * num + off) / den);
  endfunction

  function automatic bit is_alt(input logic [7:0] g);
    return (g == 8'd1) || (g == 8'd2);
  endfunction

  task automatic step(input logic r, input logic h, input logic [7:0] g, input bit c);
    ent_t       e;
    logic [7:0] gnew;
    logic [17:0] v;
    rst_n = r;
    hold  = h;
    game  = g;
    v = 18'd0;
    e.msk = {18{1'b1}};
    e.cnt = c;
    e.rst = !r;
    if (!r) begin
      n = 0;
      gnew = 8'd0;
    end else begin
      gnew = g;
      if (!h) begin
        n++;
        v[17] = strobe(n, 9, 64);
        v[16] = strobe_b(n, 9, 64);
        if (v[17]) begin
          v[15] = (((n * 9) / 64) % 2) == 0;
          v[14] = (((n * 9) / 64) % 2) == 1;
        end
        v[13] = strobe(n, 1, 24);
        v[12] = strobe_b(n, 1, 24);
        v[11] = strobe(n, 1, 48);
        v[10] = strobe_b(n, 1, 48);
        v[9]  = strobe(n, 9, 256);
        v[8]  = strobe_b(n, 9, 256);
        v[7]  = strobe(n, 9, 512);
        v[6]  = strobe_b(n, 9, 512);
        v[5]  = strobe(n, 1, 96);
        v[4]  = strobe_b(n, 1, 96);
      end
    end
    v[3] = is_alt(gnew) ? v[9] : v[13];
    v[2] = is_alt(gnew) ? v[7] : v[11];
    v[1] = is_alt(gnew) ? v[5] : v[11];
    v[0] = v[13];
    // On the cycle where the selection changes one irregular period is allowed.
    if (is_alt(gnew) != is_alt(game_reg)) e.msk[3:1] = 3'b000;
    game_reg = gnew;
    e.exp = v;
    e.n = n;
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor: pop one expectation per edge and compare, plus structural checks.
  initial begin
    logic [17:0] obs;
    logic [17:0] prev;
    bit          next_b;
    ent_t        e;
    prev = 18'd0;
    next_b = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        obs = {CEN1350, CEN1350B, CEN675, CEN675B, CEN4, CEN4B, CEN2, CEN2B,
               CEN3P375, CEN3P375B, CEN1P6875, CEN1P6875B, CEN1, CEN1B,
               YM_CEN, YM_CEN2, OKI_CEN, Z80_CEN};
        checks++;
        if ((obs & e.msk) !== (e.exp & e.msk)) begin
          failures++;
          $display("FAIL vec n=%0d got=%b exp=%b mask=%b", e.n, obs, e.exp, e.msk);
        end
        checks++;
        if ((obs[3:1] & prev[3:1]) != 3'b000) begin
          failures++;
          $display("FAIL mux_wide n=%0d got=%b prev=%b", e.n, obs[3:1], prev[3:1]);
        end
        if (e.rst) next_b = 1'b1;
        if (obs[15] || obs[14]) begin
          checks++;
          if (!obs[17] || (obs[15] && obs[14]) || (obs[14] != next_b)) begin
            failures++;
            $display("FAIL px_lock n=%0d got675=%b got675b=%b got1350=%b want675b=%b",
                     e.n, obs[15], obs[14], obs[17], next_b);
          end
          next_b = !obs[14];
        end
        if (e.cnt) begin
          for (int b = 0; b < 18; b++) cnt[b] += int'(obs[b]);
          if (obs[13] && first4 == 0) first4 = e.n;
          if (obs[12] && first4b == 0) first4b = e.n;
        end
        prev = obs;
      end
    end
  end

  task automatic chk_eq(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic chk_near(input string nm, input int got, input int want);
    checks++;
    if (got < want - 1 || got > want + 1) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d+-1", nm, got, want);
    end
  endtask

  initial begin
    bit         h;
    logic [7:0] g;
    for (int b = 0; b < 18; b++) cnt[b] = 0;
    repeat (3) step(1'b0, 1'b0, 8'd0, 1'b0);
    // 19200 enabled cycles = 200 us from phase 0.
    repeat (19200) step(1'b1, 1'b0, 8'd0, 1'b1);
    chk_eq("first_cen4", int'(first4), 24);
    chk_eq("first_cen4b", int'(first4b), 12);
    chk_eq("cnt1350", cnt[17], 2700);
    chk_near("cnt1350b", cnt[16], 2700);
    chk_eq("cnt675", cnt[15], 1350);
    chk_eq("cnt675b", cnt[14], 1350);
    chk_eq("cnt4", cnt[13], 800);
    chk_near("cnt4b", cnt[12], 800);
    chk_eq("cnt2", cnt[11], 400);
    chk_near("cnt2b", cnt[10], 400);
    chk_eq("cnt3p375", cnt[9], 675);
    chk_near("cnt3p375b", cnt[8], 675);
    chk_eq("cnt1p6875", cnt[7], 337);
    chk_near("cnt1p6875b", cnt[6], 337);
    chk_eq("cnt1", cnt[5], 200);
    chk_near("cnt1b", cnt[4], 200);
    chk_eq("cntz80", cnt[0], 800);
    // Game switch to Sorcer Striker, then random game values.
    repeat (2000) step(1'b1, 1'b0, 8'd1, 1'b0);
    for (int k = 0; k < 20; k++) begin
      g = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 0) g = 8'($urandom_range(0, 3));
      repeat (300) step(1'b1, 1'b0, g, 1'b0);
    end
    // Long hold, then resume.
    repeat (1000) step(1'b1, 1'b1, 8'd2, 1'b0);
    repeat (1000) step(1'b1, 1'b0, 8'd2, 1'b0);
    // Reset mid-run, then restart from phase 0.
    repeat (3) step(1'b0, 1'b0, 8'd0, 1'b0);
    repeat (2000) step(1'b1, 1'b0, 8'd0, 1'b0);
    // Random mix of resets, holds and game changes.
    h = 1'b0;
    g = 8'd0;
    for (int k = 0; k < 15000; k++) begin
      if ($urandom_range(0, 39) == 0) h = !h;
      if ($urandom_range(0, 199) == 0) g = 8'($urandom_range(0, 4));
      step(($urandom_range(0, 799) != 0), h, g, 1'b0);
    end
    chk_eq("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
